// File: rtl/note_sequencer.sv
`timescale 1ns/1ps
// note_sequencer: tempo-driven playback controller between the song RAM and
// the playfield datapath. Steps through note words at one of eight tempos,
// offers each note on a valid/ready handshake and flags beat overruns.
// Optional build macro: NOTE_SEQ_LOOP_EN -- end of song restarts playback at
// address 0 instead of parking in DONE.
//
// Handshake: a note transfers on every cycle where note_valid_o && note_ready_i.
// note_valid_o is registered, note_data_o is held stable while it is high, and
// it only drops after a transfer, a stop or a reset.
module note_sequencer #(
  parameter int unsigned CYC_PER_SEC = 50_000_000,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              pause_i,
  input  logic [2:0]        speed_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       note_data_o,
  output logic              note_valid_o,
  input  logic              note_ready_i,
  output logic              beat_tick_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [2:0]        state_o
);

  // Cycles per beat for a tempo select, rounded to nearest, 64-bit math.
  function automatic logic [63:0] beat_period(input int unsigned sel);
    logic [63:0] bpm;
    case (sel)
      0:       bpm = 64'd40;
      1:       bpm = 64'd60;
      2:       bpm = 64'd80;
      3:       bpm = 64'd100;
      4:       bpm = 64'd120;
      5:       bpm = 64'd140;
      6:       bpm = 64'd180;
      default: bpm = 64'd220;
    endcase
    return (64'(CYC_PER_SEC) * 64'd60 + bpm / 64'd2) / bpm;
  endfunction

  // The slowest tempo has the longest period and sets the counter width.
  localparam logic [63:0] P0    = beat_period(0);
  localparam int          CNT_W = (P0 > 64'd1) ? int'($clog2(P0)) : 1;

  localparam logic [CNT_W-1:0] RL0 = CNT_W'(beat_period(0) - 64'd1);
  localparam logic [CNT_W-1:0] RL1 = CNT_W'(beat_period(1) - 64'd1);
  localparam logic [CNT_W-1:0] RL2 = CNT_W'(beat_period(2) - 64'd1);
  localparam logic [CNT_W-1:0] RL3 = CNT_W'(beat_period(3) - 64'd1);
  localparam logic [CNT_W-1:0] RL4 = CNT_W'(beat_period(4) - 64'd1);
  localparam logic [CNT_W-1:0] RL5 = CNT_W'(beat_period(5) - 64'd1);
  localparam logic [CNT_W-1:0] RL6 = CNT_W'(beat_period(6) - 64'd1);
  localparam logic [CNT_W-1:0] RL7 = CNT_W'(beat_period(7) - 64'd1);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_OFFER = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // End of song is not a resting state: it resolves straight into the
  // next fetch (looping build) or into DONE.
`ifdef NOTE_SEQ_LOOP_EN
  localparam state_t END_STATE = S_FETCH;
`else
  localparam state_t END_STATE = S_DONE;
`endif

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        note_q, note_d;
  logic               ovr_q, ovr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_en_q, valid_q, busy_q, done_q;
  logic [CNT_W-1:0]   reload;
  logic               tick;

  // Reload value for the currently selected tempo; sampled only at load time.
  always_comb begin
    case (speed_i)
      3'd0:    reload = RL0;
      3'd1:    reload = RL1;
      3'd2:    reload = RL2;
      3'd3:    reload = RL3;
      3'd4:    reload = RL4;
      3'd5:    reload = RL5;
      3'd6:    reload = RL6;
      default: reload = RL7;
    endcase
  end

  assign tick = busy_q && !pause_i && (cnt_q == '0);

  // Next-state logic: beat counter, playback FSM, overrun flag; stop wins.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    note_d  = note_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;

    if (busy_q && !pause_i) begin
      cnt_d = tick ? reload : cnt_q - CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          addr_d  = '0;
          ovr_d   = 1'b0;
          cnt_d   = reload;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        note_d = mem_rdata_i;
        if (mem_rdata_i == 32'h0) begin
          addr_d  = '0;
          state_d = END_STATE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (tick) state_d = S_OFFER;
      end
      S_OFFER: begin
        if (note_ready_i) begin
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            state_d = END_STATE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else if (tick) begin
          // Beat arrived with the note still pending: flag it, keep offering.
          ovr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop_i) begin
      state_d = S_IDLE;
      addr_d  = '0;
      note_d  = '0;
      ovr_d   = ovr_q;
      cnt_d   = cnt_q;
    end
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      note_q  <= '0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
      rd_en_q <= (state_d == S_FETCH);
      valid_q <= (state_d == S_OFFER);
      busy_q  <= !((state_d == S_IDLE) || (state_d == S_DONE));
      done_q  <= (state_d == S_DONE);
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_rd_en_o  = rd_en_q;
  assign note_data_o  = note_q;
  assign note_valid_o = valid_q;
  assign beat_tick_o  = tick;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overrun_o    = ovr_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
`timescale 1ns/1ps
module tb_note_sequencer;

  localparam int CYC = 40;
  localparam int AW  = 6;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [2:0]  speed = 3'd0;
  logic [AW-1:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] note_data;
  logic        note_valid;
  logic        note_ready = 1'b1;
  logic        beat_tick, busy, done, overrun;
  logic [2:0]  state_dbg;

  logic [31:0] ram [64];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Song RAM model: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  note_sequencer #(.CYC_PER_SEC(CYC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .pause_i(pause),
    .speed_i(speed), .mem_addr_o(mem_addr), .mem_rd_en_o(mem_rd_en),
    .mem_rdata_i(mem_rdata), .note_data_o(note_data), .note_valid_o(note_valid),
    .note_ready_i(note_ready), .beat_tick_o(beat_tick), .busy_o(busy),
    .done_o(done), .overrun_o(overrun), .state_o(state_dbg)
  );

  // ---------------- helpers / drivers ----------------
  function automatic int per(input int s);
    int bpm;
    case (s)
      0: bpm = 40;  1: bpm = 60;  2: bpm = 80;  3: bpm = 100;
      4: bpm = 120; 5: bpm = 140; 6: bpm = 180; default: bpm = 220;
    endcase
    return (CYC * 60 + bpm / 2) / bpm;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fill_song(input int n);
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom();
      if (ram[i] == 32'h0) ram[i] = 32'h1;
    end
    if (n < 64) ram[n] = 32'h0;
  endtask

  task automatic do_start(output int t);
    start = 1'b1;
    t = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      if (beat_tick === 1'b1) begin
        at = cyc;
        return;
      end
      step();
    end
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      if (done === 1'b1) begin
        at = cyc;
        return;
      end
      step();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [43:0] obs;
    repeat (2) step();
    obs = {note_data, mem_addr, mem_rd_en, note_valid, beat_tick, busy, done, overrun};
    checks++;
    if (obs !== 44'h0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", obs);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({busy, done, beat_tick} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got busy/done/tick %b want 000", {busy, done, beat_tick});
    end
  endtask

  task automatic test_basic();
    int t, at;
    fill_song(3);
    speed = 3'd0; note_ready = 1'b1;
    do_start(t);
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_fetch: got rd_en %b addr %0d busy %b want 1 0 1", mem_rd_en, mem_addr, busy);
    end
    for (int i = 0; i < 3; i++) begin
      wait_tick(200, at);
      checks++;
      if (at != t + per(0) * (i + 1)) begin
        errors++; $display("FAIL basic_beat%0d: got cycle %0d want %0d", i, at - t, per(0) * (i + 1));
      end
      step();
      checks++;
      if (note_valid !== 1'b1 || note_data !== ram[i]) begin
        errors++; $display("FAIL basic_note%0d: got valid %b data %h want 1 %h", i, note_valid, note_data, ram[i]);
      end
    end
`ifdef NOTE_SEQ_LOOP_EN
    wait_tick(200, at);
    step();
    checks++;
    if (at != t + per(0) * 4 || note_data !== ram[0] || done !== 1'b0) begin
      errors++; $display("FAIL basic_loop: got cycle %0d data %h done %b want %0d %h 0", at - t, note_data, done, per(0) * 4, ram[0]);
    end
    do_stop();
`else
    wait_done(10, at);
    checks++;
    if (at < 0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done: got done_at %0d busy %b want done with busy 0", at, busy);
    end
    wait_tick(100, at);
    checks++;
    if (at != -1) begin
      errors++; $display("FAIL basic_no_tick_in_done: got tick at %0d want none", at);
    end
`endif
  endtask

  task automatic test_speed_change();
    int t, at;
    fill_song(10);
    speed = 3'd0; note_ready = 1'b1;
    do_start(t);
    repeat (29) step();
    speed = 3'd7;
    for (int i = 0; i < 3; i++) begin
      wait_tick(200, at);
      checks++;
      if (at != t + per(0) + per(7) * i) begin
        errors++; $display("FAIL speed_beat%0d: got cycle %0d want %0d", i, at - t, per(0) + per(7) * i);
      end
      step();
      checks++;
      if (note_valid !== 1'b1 || note_data !== ram[i]) begin
        errors++; $display("FAIL speed_note%0d: got valid %b data %h want 1 %h", i, note_valid, note_data, ram[i]);
      end
    end
    do_stop();
  endtask

  task automatic test_overrun();
    int t, at;
    fill_song(5);
    speed = 3'd0; note_ready = 1'b0;
    do_start(t);
    wait_tick(200, at);
    step();
    checks++;
    if (note_valid !== 1'b1 || note_data !== ram[0] || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first: got valid %b data %h ovr %b want 1 %h 0", note_valid, note_data, overrun, ram[0]);
    end
    wait_tick(200, at);
    step();
    checks++;
    if (at != t + 2 * per(0) || overrun !== 1'b1 || note_valid !== 1'b1 || note_data !== ram[0]) begin
      errors++; $display("FAIL ovr_set: got cycle %0d ovr %b valid %b data %h want %0d 1 1 %h", at - t, overrun, note_valid, note_data, 2 * per(0), ram[0]);
    end
    wait_tick(200, at);
    step();
    note_ready = 1'b1;
    step();
    checks++;
    if (note_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_accept: got valid %b want 0", note_valid);
    end
    wait_tick(200, at);
    step();
    checks++;
    if (at != t + 4 * per(0) || note_data !== ram[1] || note_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_next: got cycle %0d data %h valid %b ovr %b want %0d %h 1 1", at - t, note_data, note_valid, overrun, 4 * per(0), ram[1]);
    end
    do_stop();
  endtask

  task automatic test_pause();
    int t, at;
    bit tick_seen;
    fill_song(5);
    speed = 3'd0; note_ready = 1'b1;
    do_start(t);
    repeat (9) step();
    pause = 1'b1;
    tick_seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (beat_tick === 1'b1) tick_seen = 1'b1;
    end
    pause = 1'b0;
    checks++;
    if (tick_seen) begin
      errors++; $display("FAIL pause_tick_suppressed: got tick during pause want none");
    end
    for (int i = 0; i < 2; i++) begin
      wait_tick(200, at);
      checks++;
      if (at != t + per(0) * (i + 1) + 25) begin
        errors++; $display("FAIL pause_beat%0d: got cycle %0d want %0d", i, at - t, per(0) * (i + 1) + 25);
      end
      step();
      checks++;
      if (note_valid !== 1'b1 || note_data !== ram[i]) begin
        errors++; $display("FAIL pause_note%0d: got valid %b data %h want 1 %h", i, note_valid, note_data, ram[i]);
      end
    end
    do_stop();
  endtask

  task automatic test_full_song();
    int t, at;
    int bad_time, bad_note;
    fill_song(64);
    speed = 3'd7; note_ready = 1'b1;
    do_start(t);
    bad_time = 0; bad_note = 0;
    for (int i = 0; i < 64; i++) begin
      wait_tick(40, at);
      if (at != t + per(7) * (i + 1)) bad_time++;
      step();
      if (note_valid !== 1'b1 || note_data !== ram[i]) bad_note++;
    end
    checks++;
    if (bad_time != 0) begin
      errors++; $display("FAIL full_beat_times: got %0d late/missing beats want 0", bad_time);
    end
    checks++;
    if (bad_note != 0) begin
      errors++; $display("FAIL full_notes: got %0d wrong notes want 0", bad_note);
    end
`ifdef NOTE_SEQ_LOOP_EN
    wait_tick(40, at);
    step();
    checks++;
    if (at != t + per(7) * 65 || note_data !== ram[0] || note_valid !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL full_wrap: got cycle %0d data %h valid %b done %b want %0d %h 1 0", at - t, note_data, note_valid, done, per(7) * 65, ram[0]);
    end
`else
    wait_done(10, at);
    checks++;
    if (at < 0 || busy !== 1'b0) begin
      errors++; $display("FAIL full_done: got done_at %0d busy %b want done with busy 0", at, busy);
    end
`endif
    do_stop();
  endtask

  task automatic test_stop_reset();
    int t, at;
    logic [43:0] obs;
    fill_song(5);
    speed = 3'd7; note_ready = 1'b0;
    do_start(t);
    wait_tick(40, at);
    step();
    #2 rst = 1'b1;
    #1;
    obs = {note_data, mem_addr, mem_rd_en, note_valid, beat_tick, busy, done, overrun};
    checks++;
    if (obs !== 44'h0) begin
      errors++; $display("FAIL async_reset: got %h want 0", obs);
    end
    step();
    rst = 1'b0;
    step();
    note_ready = 1'b1;
    do_start(t);
    checks++;
    if (mem_addr !== '0 || mem_rd_en !== 1'b1) begin
      errors++; $display("FAIL restart_after_reset: got addr %0d rd_en %b want 0 1", mem_addr, mem_rd_en);
    end
    wait_tick(40, at);
    step();
    checks++;
    if (at != t + per(7) || note_data !== ram[0]) begin
      errors++; $display("FAIL reset_first_note: got cycle %0d data %h want %0d %h", at - t, note_data, per(7), ram[0]);
    end
    do_stop();
    note_ready = 1'b0;
    do_start(t);
    wait_tick(40, at);
    step();
    wait_tick(40, at);
    step();
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL stop_ovr_setup: got ovr %b want 1", overrun);
    end
    note_ready = 1'b1;
    step();
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 6'd1) begin
      errors++; $display("FAIL stop_fetch2: got rd_en %b addr %0d want 1 1", mem_rd_en, mem_addr);
    end
    step();
    do_stop();
    obs = {note_data, mem_addr, mem_rd_en, note_valid, beat_tick, busy, done, overrun};
    checks++;
    if (obs !== 44'h1) begin
      errors++; $display("FAIL stop_in_wait: got %h want 1 (only overrun kept)", obs);
    end
    do_start(t);
    checks++;
    if (overrun !== 1'b0 || mem_addr !== '0 || mem_rd_en !== 1'b1) begin
      errors++; $display("FAIL restart_after_stop: got ovr %b addr %0d rd_en %b want 0 0 1", overrun, mem_addr, mem_rd_en);
    end
    wait_tick(40, at);
    step();
    checks++;
    if (note_data !== ram[0]) begin
      errors++; $display("FAIL stop_first_note: got %h want %h", note_data, ram[0]);
    end
    do_stop();
  endtask

  // Randomized playback against a time-based model: beats fall at absolute
  // cycles (start + period, shifted by paused cycles), a note is ready to be
  // offered three cycles after the previous transfer, and a beat with a
  // pending note sets overrun.
  task automatic test_random();
    int t, next_tick, hold_from, end_at, budget;
    bit offering, exp_ovr, exp_busy, exp_tick, hs, finished;
    logic [31:0] exp_q[$];
    int n_notes;
    n_notes = $urandom_range(1, 8);
    fill_song(n_notes);
    exp_q.delete();
    for (int i = 0; i < n_notes; i++) exp_q.push_back(ram[i]);
    speed = 3'($urandom_range(0, 7));
    pause = 1'b0;
    note_ready = 1'b1;
    do_start(t);
    next_tick = t + per(int'(speed));
    hold_from = t + 3;
    end_at = -1;
    offering = 1'b0; exp_ovr = 1'b0; exp_busy = 1'b1; finished = 1'b0;
    budget = 0;
    while (budget < 4000) begin
      if ($urandom_range(0, 9) == 0) speed = 3'($urandom_range(0, 7));
      note_ready = ($urandom_range(0, 9) < 7);
      pause = ($urandom_range(0, 9) == 0);
      #1;
      if (cyc == end_at) begin
`ifndef NOTE_SEQ_LOOP_EN
        exp_busy = 1'b0;
`endif
        finished = 1'b1;
      end
      exp_tick = exp_busy && !pause && (cyc == next_tick);
      hs = offering && note_ready;
      checks++;
      if (beat_tick !== exp_tick) begin
        errors++; $display("FAIL rnd_tick@%0d: got %b want %b", cyc - t, beat_tick, exp_tick);
      end
      checks++;
      if (note_valid !== offering) begin
        errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc - t, note_valid, offering);
      end
      if (offering) begin
        checks++;
        if (note_data !== exp_q[0]) begin
          errors++; $display("FAIL rnd_data@%0d: got %h want %h", cyc - t, note_data, exp_q[0]);
        end
      end
      checks++;
      if (overrun !== exp_ovr) begin
        errors++; $display("FAIL rnd_ovr@%0d: got %b want %b", cyc - t, overrun, exp_ovr);
      end
      checks++;
      if (busy !== exp_busy || done !== !exp_busy) begin
        errors++; $display("FAIL rnd_busy_done@%0d: got %b%b want %b%b", cyc - t, busy, done, exp_busy, !exp_busy);
      end
      if (finished) break;
      if (exp_busy && pause) next_tick++;
      if (exp_tick) next_tick = cyc + per(int'(speed));
      if (hs) begin
        void'(exp_q.pop_front());
        offering = 1'b0;
        if (exp_q.size() == 0) end_at = cyc + 3;
        else hold_from = cyc + 3;
      end else if (offering && exp_tick) begin
        exp_ovr = 1'b1;
      end else if (!offering && exp_tick && exp_q.size() > 0 && cyc >= hold_from) begin
        offering = 1'b1;
      end
      step();
      budget++;
    end
    checks++;
    if (!finished) begin
      errors++; $display("FAIL rnd_timeout: got %0d notes left want 0", exp_q.size());
    end
    pause = 1'b0;
    note_ready = 1'b1;
    do_stop();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_speed_change();
    test_overrun();
    test_pause();
    test_full_song();
    test_stop_reset();
    for (int r = 0; r < 4; r++) test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
